// File: rtl/uart_hex_sender.sv
// Formats a channel/measurement pair as an ASCII hex line and writes it into the UART TX FIFO.
// Define UART_HEX_SENDER_CKSUM_EN to append '*' plus a two-digit XOR checksum before CR LF.
module uart_hex_sender #(
  parameter logic [7:0] SEP_CHAR  = 8'h3A,
  parameter bit         UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  chan,
  input  logic [15:0] data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        done
);

`ifdef UART_HEX_SENDER_CKSUM_EN
  localparam logic [3:0] LAST = 4'd10;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [3:0]  chan_q;
  logic [15:0] data_q;
  logic        wr_n, busy_n, done_n;
  logic [7:0]  w_data_n;
  logic [7:0]  cur_byte;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

`ifdef UART_HEX_SENDER_CKSUM_EN
  logic [7:0] cksum;

  assign cksum = hex(chan_q) ^ SEP_CHAR
               ^ hex(data_q[15:12]) ^ hex(data_q[11:8])
               ^ hex(data_q[7:4]) ^ hex(data_q[3:0]);

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      4'd0:    cur_byte = hex(chan_q);
      4'd1:    cur_byte = SEP_CHAR;
      4'd2:    cur_byte = hex(data_q[15:12]);
      4'd3:    cur_byte = hex(data_q[11:8]);
      4'd4:    cur_byte = hex(data_q[7:4]);
      4'd5:    cur_byte = hex(data_q[3:0]);
      4'd6:    cur_byte = 8'h2A;
      4'd7:    cur_byte = hex(cksum[7:4]);
      4'd8:    cur_byte = hex(cksum[3:0]);
      4'd9:    cur_byte = 8'h0D;
      4'd10:   cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end
`else
  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      4'd0:    cur_byte = hex(chan_q);
      4'd1:    cur_byte = SEP_CHAR;
      4'd2:    cur_byte = hex(data_q[15:12]);
      4'd3:    cur_byte = hex(data_q[11:8]);
      4'd4:    cur_byte = hex(data_q[7:4]);
      4'd5:    cur_byte = hex(data_q[3:0]);
      4'd6:    cur_byte = 8'h0D;
      4'd7:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end
`endif

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    wr_n     = 1'b0;
    w_data_n = w_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          idx_n   = 4'd0;
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr_n     = 1'b1;
          w_data_n = cur_byte;
          state_n  = GAP;
        end
      end
      GAP: begin
        if (idx == LAST) begin
          state_n = FIN;
        end else begin
          idx_n   = idx + 4'd1;
          state_n = SEND;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SEND) || (state_n == GAP);
    done_n = (state_n == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      chan_q  <= 4'd0;
      data_q  <= 16'd0;
      wr_uart <= 1'b0;
      w_data  <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      wr_uart <= wr_n;
      w_data  <= w_data_n;
      busy    <= busy_n;
      done    <= done_n;
      if (state == IDLE && start) begin
        chan_q <= chan;
        data_q <= data;
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Bench for uart_hex_sender: an uppercase and a lowercase instance share stimulus,
// frames are compared against table rows and a queue-based model.
module tb_uart_hex_sender;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [3:0]  c;
    logic [15:0] d;
    logic [47:0] up6;
    logic [47:0] lo6;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tx_full = 1'b0;
  logic [3:0]  chan = 4'd0;
  logic [15:0] data = 16'd0;
  logic        wr0, wr1, bz0, bz1, dn0, dn1;
  logic [7:0]  wd0, wd1;

  int  checks = 0;
  int  errors = 0;
  int  viol = 0;
  int  dc0 = 0;
  int  dc1 = 0;
  bit  rnd_full = 1'b0;
  bq_t q0, q1;

  uart_hex_sender dut0 (
    .clk(clk), .reset(reset), .start(start), .chan(chan), .data(data),
    .tx_full(tx_full), .wr_uart(wr0), .w_data(wd0), .busy(bz0), .done(dn0)
  );

  uart_hex_sender #(.UPPERCASE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .chan(chan), .data(data),
    .tx_full(tx_full), .wr_uart(wr1), .w_data(wd1), .busy(bz1), .done(dn1)
  );

  always #10 clk = ~clk;

  // Byte capture plus protocol rules: no write into a full FIFO, never two
  // writes in a row, done only as a single pulse with busy low.
  logic fs, rs;
  logic pw0 = 1'b0;
  logic pd0 = 1'b0;
  always @(posedge clk) begin
    fs = tx_full;
    rs = reset;
    #1;
    if (!rs && !reset) begin
      if (wr0) q0.push_back(wd0);
      if (wr1) q1.push_back(wd1);
      if (wr0 && fs) viol++;
      if (wr0 && pw0) viol++;
      if (wr0 && !bz0) viol++;
      if (wr0 !== wr1 || bz0 !== bz1 || dn0 !== dn1) viol++;
      if (dn0 && (bz0 || pd0)) viol++;
      if (dn0) dc0++;
      if (dn1) dc1++;
    end
    pw0 = wr0;
    pd0 = dn0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n, input bit up);
    if (n < 10) return 8'(48 + n);
    return 8'((up ? 65 : 97) + n - 10);
  endfunction

  function automatic bq_t with_tail(input bq_t f, input bit up);
    bq_t r = f;
`ifdef UART_HEX_SENDER_CKSUM_EN
    int x = 0;
    for (int i = 0; i < 6; i++) x = x ^ int'(f[i]);
    r.push_back(8'h2A);
    r.push_back(hexc(x / 16, up));
    r.push_back(hexc(x % 16, up));
`endif
    r.push_back(8'h0D);
    r.push_back(8'h0A);
    return r;
  endfunction

  function automatic bq_t model(input int c, input int d, input bit up);
    bq_t f;
    f.push_back(hexc(c, up));
    f.push_back(8'h3A);
    for (int s = 12; s >= 0; s -= 4) f.push_back(hexc((d >> s) % 16, up));
    return with_tail(f, up);
  endfunction

  function automatic bq_t from_row(input logic [47:0] six, input bit up);
    bq_t f;
    logic [47:0] t = six;
    for (int i = 0; i < 6; i++) begin
      f.push_back(t[47:40]);
      t = t << 8;
    end
    return with_tail(f, up);
  endfunction

  task automatic cmp_frame(input string nm, input bq_t got, input bq_t exp);
    chk({nm, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s byte%0d", nm, i),
          (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  task automatic pulse_start(input logic [3:0] c, input logic [15:0] d);
    @(negedge clk);
    chan = c;
    data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int base, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (rnd_full) tx_full = ($urandom_range(0, 2) == 0);
      if (dc0 > base) got = 1'b1;
    end
    tx_full = 1'b0;
    chk({nm, " done seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_size(input int n, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (q0.size() >= n) got = 1'b1;
    end
    chk({nm, " bytes reached"}, 32'(got), 32'd1);
  endtask

  initial begin
    vec_t tbl[5];
    int   base;
    logic [3:0]  rc;
    logic [15:0] rd;

    tbl[0] = '{4'h3, 16'h1A2F, 48'h333A31413246, 48'h333A31613266};
    tbl[1] = '{4'hB, 16'hCAFE, 48'h423A43414645, 48'h623A63616665};
    tbl[2] = '{4'h0, 16'h0000, 48'h303A30303030, 48'h303A30303030};
    tbl[3] = '{4'hF, 16'hFFFF, 48'h463A46464646, 48'h663A66666666};
    tbl[4] = '{4'h9, 16'h0123, 48'h393A30313233, 48'h393A30313233};

    repeat (3) @(negedge clk);
    chk("reset wr_uart", 32'(wr0), 32'd0);
    chk("reset busy", 32'(bz0), 32'd0);
    chk("reset done", 32'(dn0), 32'd0);
    chk("reset w_data", 32'(wd0), 32'd0);
    chk("reset lc wr_uart", 32'(wr1), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame with cycle-exact latency
    base = dc0;
    chan = 4'h3;
    data = 16'h1A2F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy after accept", 32'(bz0), 32'd1);
    chk("no wr at accept", 32'(wr0), 32'd0);
    @(negedge clk);
    chk("first wr", 32'(wr0), 32'd1);
    chk("first byte", 32'(wd0), 32'h33);
    @(negedge clk);
    chk("gap wr", 32'(wr0), 32'd0);
    chk("w_data hold", 32'(wd0), 32'h33);
    chk("busy in gap", 32'(bz0), 32'd1);
    wait_frame(base, "basic");
    chk("busy low at done", 32'(bz0), 32'd0);
    cmp_frame("basic uc", q0, from_row(tbl[0].up6, 1'b1));
    cmp_frame("basic lc", q1, from_row(tbl[0].lo6, 1'b0));
    @(negedge clk);
    chk("done single", 32'(dn0), 32'd0);
    chk("w_data last", 32'(wd0), 32'h0A);
    q0.delete();
    q1.delete();

    for (int i = 0; i < 5; i++) begin
      base = dc0;
      pulse_start(tbl[i].c, tbl[i].d);
      wait_frame(base, $sformatf("row%0d", i));
      cmp_frame($sformatf("row%0d uc", i), q0, from_row(tbl[i].up6, 1'b1));
      cmp_frame($sformatf("row%0d lc", i), q1, from_row(tbl[i].lo6, 1'b0));
      q0.delete();
      q1.delete();
    end

    // backpressure stall with an ignored start in the middle
    base = dc0;
    pulse_start(4'h3, 16'h1A2F);
    wait_size(3, "stall");
    tx_full = 1'b1;
    repeat (5) @(negedge clk);
    chan = 4'hF;
    data = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("stall no bytes", 32'(q0.size()), 32'd3);
    tx_full = 1'b0;
    wait_frame(base, "stall");
    // start during the FIN cycle must not launch a frame
    chan = 4'h5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp_frame("stall uc", q0, from_row(tbl[0].up6, 1'b1));
    q0.delete();
    q1.delete();
    repeat (40) @(negedge clk);
    chk("no extra frame", 32'(q0.size()), 32'd0);
    chk("one done", 32'(dc0 - base), 32'd1);

    // reset mid-frame
    pulse_start(4'h7, 16'h1234);
    wait_size(4, "abort");
    reset = 1'b1;
    #1;
    chk("abort wr_uart", 32'(wr0), 32'd0);
    chk("abort busy", 32'(bz0), 32'd0);
    chk("abort done", 32'(dn0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    base = dc0;
    pulse_start(4'h0, 16'h0000);
    wait_frame(base, "after abort");
    cmp_frame("after abort uc", q0, from_row(tbl[2].up6, 1'b1));
    chk("after abort done count", 32'(dc0 - base), 32'd1);
    q0.delete();
    q1.delete();

    // random frames under random backpressure
    rnd_full = 1'b1;
    for (int k = 0; k < 25; k++) begin
      rc = 4'($urandom % 16);
      rd = 16'($urandom % 65536);
      base = dc0;
      pulse_start(rc, rd);
      wait_frame(base, $sformatf("rnd%0d", k));
      cmp_frame($sformatf("rnd%0d uc", k), q0, model(int'(rc), int'(rd), 1'b1));
      cmp_frame($sformatf("rnd%0d lc", k), q1, model(int'(rc), int'(rd), 1'b0));
      q0.delete();
      q1.delete();
    end
    rnd_full = 1'b0;
    tx_full = 1'b0;

    chk("protocol violations", 32'(viol), 32'd0);
    chk("done count match", 32'(dc0), 32'(dc1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
